// File: rtl/sched_pkg.sv
// Shared types and defaults for the round-robin grant scheduler.
// Holds the FSM state enum, the idle grant-id sentinel and default sizes.
package sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int           DEF_N        = 16;
    localparam int           DEF_MAX_HOLD = 8;
    localparam int           DEF_ID_W     = 8;
    localparam logic [7:0]   DEF_IDLE_ID  = 8'hF0;

    // Index width for an N-entry vector; a 1-entry index still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority pick: lowest requester at or above ptr, else lowest overall.
// Ports: req (request vector), ptr (search start) -> any (some request), idx (winner).
module rr_priority_pick
    import sched_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0]     masked;
    logic             hit_m;
    logic             hit_f;
    logic [IDX_W-1:0] idx_m;
    logic [IDX_W-1:0] idx_f;

    always_comb begin
        masked = '0;
        hit_m  = 1'b0;
        hit_f  = 1'b0;
        idx_m  = '0;
        idx_f  = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (IDX_W'(i) >= ptr);
        end
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                hit_m = 1'b1;
                idx_m = IDX_W'(i);
            end
            if (req[i]) begin
                hit_f = 1'b1;
                idx_f = IDX_W'(i);
            end
        end
        any = hit_f;
        // Nothing at or above ptr means the search wraps to index 0.
        idx = hit_m ? idx_m : idx_f;
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin arbiter granting one shared slot with hold limit, lock and preempt.
// Ports: clk, rst, en, req, lock -> gnt, gnt_valid, gnt_id, preempt (all registered).
module rr_grant_scheduler
    import sched_pkg::*;
#(
    parameter int              N        = DEF_N,
    parameter int              MAX_HOLD = DEF_MAX_HOLD,
    parameter int              ID_W     = DEF_ID_W,
    parameter logic [ID_W-1:0] IDLE_ID  = ID_W'(DEF_IDLE_ID)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic            lock,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id,
    output logic            preempt
);

    localparam int IDX_W = idx_width(N);
    localparam int HC_W  = $clog2(MAX_HOLD);

    localparam logic [HC_W-1:0]  HOLD_SAT = HC_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [N-1:0]     ONE_N    = N'(1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cur;
    logic [HC_W-1:0]  hold_cnt;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             hold_sat;
    logic             rel;
    logic             pre;
    logic [IDX_W-1:0] ptr_next;

    rr_priority_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign hold_sat = (hold_cnt == HOLD_SAT);
    assign rel      = !req[cur];
    // Force-release only once the hold budget is used and someone else waits.
    assign pre      = hold_sat && !lock && (|(req & ~gnt));
    // Move the search start just past the outgoing holder.
    assign ptr_next = (cur == LAST_IDX) ? '0 : cur + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= IDLE_ID;
            preempt   <= 1'b0;
            ptr       <= '0;
            cur       <= '0;
            hold_cnt  <= '0;
        end else begin
            preempt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en && pick_any) begin
                        state     <= GRANT;
                        cur       <= pick_idx;
                        gnt       <= ONE_N << pick_idx;
                        gnt_valid <= 1'b1;
                        gnt_id    <= ID_W'(pick_idx);
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (rel || pre) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        gnt_id    <= IDLE_ID;
                        ptr       <= ptr_next;
                        hold_cnt  <= '0;
                        // A voluntary release wins over a preempt.
                        preempt   <= !rel;
                    end else if (!hold_sat) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler with a queue of expected outputs.
// Each step pushes the expected post-edge outputs, clocks, then pops and checks.
module tb_rr_grant_scheduler;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic        lock;
    logic [15:0] gnt;
    logic        gnt_valid;
    logic [7:0]  gnt_id;
    logic        preempt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] gnt;
        logic        valid;
        logic [7:0]  id;
        logic        pre;
    } exp_t;

    exp_t sbq[$];

    rr_grant_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .lock      (lock),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [7:0] id,
                            input logic pre);
        exp_t       e;
        logic [3:0] sh;
        sh      = id[3:0];
        e.tag   = tag;
        e.id    = id;
        e.valid = (id != 8'hF0);
        e.gnt   = e.valid ? (16'h0001 << sh) : 16'h0000;
        e.pre   = pre;
        sbq.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        assert (sbq.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard empty got %0d entries req 1", sbq.size());
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            assert (gnt === e.gnt) else begin
                errors++;
                $error("FAIL %s gnt got %h exp %h", e.tag, gnt, e.gnt);
            end
            checks++;
            assert (gnt_valid === e.valid) else begin
                errors++;
                $error("FAIL %s gnt_valid got %b exp %b", e.tag, gnt_valid, e.valid);
            end
            checks++;
            assert (gnt_id === e.id) else begin
                errors++;
                $error("FAIL %s gnt_id got %h exp %h", e.tag, gnt_id, e.id);
            end
            checks++;
            assert (preempt === e.pre) else begin
                errors++;
                $error("FAIL %s preempt got %b exp %b", e.tag, preempt, e.pre);
            end
        end
    endtask

    // Push expectation, take one rising edge, sample 1 time unit later.
    task automatic step(input string tag, input logic [7:0] id,
                        input logic pre);
        push_exp(tag, id, pre);
        @(posedge clk);
        #1;
        check_out();
    endtask

    localparam logic [7:0] IDL = 8'hF0;

    initial begin
        logic [7:0] rr_seq [4];
        rr_seq[0] = 8'd0;
        rr_seq[1] = 8'd2;
        rr_seq[2] = 8'd15;
        rr_seq[3] = 8'd0;

        rst  = 1'b1;
        en   = 1'b1;
        lock = 1'b0;
        req  = 16'hFFFF;
        #2;

        // Reset with all requesters asserting
        step("rst0", IDL, 1'b0);
        step("rst1", IDL, 1'b0);
        rst = 1'b0;
        step("rst_first", 8'd0, 1'b0);
        req = 16'h0000;
        step("rel0", IDL, 1'b0);

        // Single holder keeps the grant indefinitely
        req = 16'h0020;
        for (int i = 0; i < 20; i++) step("hold5", 8'd5, 1'b0);
        req = 16'h0000;
        step("rel5", IDL, 1'b0);

        // Round robin with hold limit; reset first so ptr starts at 0
        rst = 1'b1;
        step("rst_rr", IDL, 1'b0);
        rst = 1'b0;
        req = 16'h8005;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 8; c++) step("rr_gnt", rr_seq[g], 1'b0);
            step("rr_pre", IDL, 1'b1);
        end
        req = 16'h0000;
        step("rr_idle", IDL, 1'b0);

        // Lock holds past the hold limit
        rst = 1'b1;
        step("rst_lk", IDL, 1'b0);
        rst  = 1'b0;
        req  = 16'h0003;
        lock = 1'b1;
        for (int i = 0; i < 30; i++) step("lock0", 8'd0, 1'b0);
        lock = 1'b0;
        step("lock_pre", IDL, 1'b1);
        step("lock_next", 8'd1, 1'b0);
        req = 16'h0000;
        step("lock_rel", IDL, 1'b0);

        // Enable gates only new grants
        en  = 1'b0;
        req = 16'h0010;
        for (int i = 0; i < 10; i++) step("en_off", IDL, 1'b0);
        en = 1'b1;
        step("en_on", 8'd4, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 12; i++) step("en_mid", 8'd4, 1'b0);
        req = 16'h0000;
        step("en_rel", IDL, 1'b0);

        // Reset mid-grant restarts from pointer 0 (ptr was 5 here)
        en  = 1'b1;
        req = 16'h0081;
        step("g7", 8'd7, 1'b0);
        step("g7b", 8'd7, 1'b0);
        rst = 1'b1;
        step("rst_mid", IDL, 1'b0);
        rst = 1'b0;
        step("post_rst", 8'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
